// File: rtl/dqpsk_symbol_mapper.sv
// Maps Gray-coded dibits to differentially encoded QPSK {I,Q} samples, SPS samples per symbol, with an optional phase-0 reference symbol at frame start.
// Latency: the first sample is valid one cycle after the input handshake. Back-to-back symbols leave no idle cycle between them.
// Backpressure: a stalled output holds tdata/tlast. s00_axis_tready rises only on the final beat of a symbol, gated by m00_axis_tready.
module dqpsk_symbol_mapper #(
  parameter int                C_S00_AXIS_TDATA_WIDTH = 8,
  parameter int                C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int                SPS                    = 4,
  parameter logic signed [15:0] AMP                   = 16'sd11585,
  parameter bit                REF_EN                 = 1'b1
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast
);

  localparam int              CNT_W    = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } iq_t;

  // Gray dibit to phase increment in quarter turns: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray_inc(input logic [1:0] d);
    return {d[1], d[1] ^ d[0]};
  endfunction

  // Phase index to constellation point, one point per quadrant.
  function automatic iq_t iq_of(input logic [1:0] k);
    iq_t s;
    s.i = (k[1] ^ k[0]) ? -AMP : AMP;
    s.q = k[1] ? -AMP : AMP;
    return s;
  endfunction

  state_t            state_q, state_n;
  logic [1:0]        k_q, k_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [1:0]        dibit_q, dibit_n;
  logic              last_q, last_n;
  logic              frame_start_q, frame_start_n;

  logic              m_vld_q, m_vld_n;
  iq_t               m_dat_q, m_dat_n;
  logic              m_lst_q, m_lst_n;
  logic              m_strb_q, m_strb_n;

  logic              s_rdy;
  logic              in_hs;
  logic              beat;
  logic              cnt_end;
  logic [1:0]        new_inc;
  logic [1:0]        k_base;

  // Only the dibit bits of the input word carry information.
  logic unused_in;
  assign unused_in = ^{s00_axis_tdata, s00_axis_tstrb};

  assign beat    = m_vld_q & m00_axis_tready;
  assign cnt_end = (cnt_q == CNT_LAST);
  assign new_inc = gray_inc(s00_axis_tdata[1:0]);

  // Input ready: open when idle, or on the final beat of a data symbol so the next symbol follows with no bubble.
  always_comb begin
    s_rdy = 1'b0;
    case (state_q)
      IDLE:    s_rdy = 1'b1;
      DATA:    s_rdy = cnt_end & m00_axis_tready;
      default: s_rdy = 1'b0;
    endcase
    s_rdy = s_rdy & s00_axis_aresetn;
  end

  assign in_hs           = s00_axis_tvalid & s_rdy;
  assign s00_axis_tready = s_rdy;

  // Next-state, phase and counter update, followed by the output sample the next state will present.
  always_comb begin
    state_n       = state_q;
    k_n           = k_q;
    cnt_n         = cnt_q;
    dibit_n       = dibit_q;
    last_n        = last_q;
    frame_start_n = frame_start_q;
    k_base        = last_q ? 2'd0 : k_q;

    case (state_q)
      IDLE: begin
        if (in_hs) begin
          dibit_n       = s00_axis_tdata[1:0];
          last_n        = s00_axis_tlast;
          cnt_n         = '0;
          frame_start_n = 1'b0;
          if (REF_EN && frame_start_q) begin
            state_n = REF;
            k_n     = 2'd0;
          end else begin
            state_n = DATA;
            k_n     = k_q + new_inc;
          end
        end
      end
      REF: begin
        if (beat) begin
          if (cnt_end) begin
            cnt_n   = '0;
            k_n     = gray_inc(dibit_q);
            state_n = DATA;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (beat) begin
          if (!cnt_end) begin
            cnt_n = cnt_q + CNT_W'(1);
          end else begin
            cnt_n         = '0;
            frame_start_n = last_q;
            if (in_hs) begin
              dibit_n       = s00_axis_tdata[1:0];
              last_n        = s00_axis_tlast;
              frame_start_n = 1'b0;
              if (REF_EN && last_q) begin
                state_n = REF;
                k_n     = 2'd0;
              end else begin
                state_n = DATA;
                k_n     = k_base + new_inc;
              end
            end else begin
              state_n = IDLE;
              k_n     = k_base;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    m_vld_n  = (state_n != IDLE);
    m_strb_n = m_vld_n;
    m_dat_n  = m_vld_n ? iq_of(k_n) : '0;
    m_lst_n  = (state_n == DATA) & last_n & (cnt_n == CNT_LAST);
  end

  // Control state: phase, sample counter, pending dibit and frame tracking.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q       <= IDLE;
      k_q           <= '0;
      cnt_q         <= '0;
      dibit_q       <= '0;
      last_q        <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      state_q       <= state_n;
      k_q           <= k_n;
      cnt_q         <= cnt_n;
      dibit_q       <= dibit_n;
      last_q        <= last_n;
      frame_start_q <= frame_start_n;
    end
  end

  // Registered output stage; during a stall every next value equals the current one, so the beat holds.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      m_vld_q  <= 1'b0;
      m_dat_q  <= '0;
      m_lst_q  <= 1'b0;
      m_strb_q <= 1'b0;
    end else begin
      m_vld_q  <= m_vld_n;
      m_dat_q  <= m_dat_n;
      m_lst_q  <= m_lst_n;
      m_strb_q <= m_strb_n;
    end
  end

  assign m00_axis_tvalid = m_vld_q;
  assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(m_dat_q);
  assign m00_axis_tlast  = m_lst_q;
  assign m00_axis_tstrb  = m_strb_q ? '1 : '0;

endmodule

// File: tb/tb_dqpsk_symbol_mapper.sv
`timescale 1ns/1ps
module tb_dqpsk_symbol_mapper;

  localparam int SPS_A = 4;
  localparam int SPS_B = 1;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic        s_vld  [2];
  logic        s_rdy  [2];
  logic [7:0]  s_dat  [2];
  logic [0:0]  s_strb [2];
  logic        s_lst  [2];
  logic        m_vld  [2];
  logic        m_rdy  [2];
  logic [31:0] m_dat  [2];
  logic [3:0]  m_strb [2];
  logic        m_lst  [2];

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          sb_en  [2];
  int          rmode  [2];
  bit          gap_en [2];
  logic [1:0]  dbuf   [2][16];

  // Reference tables: phase increment per dibit value, and the I/Q of each quadrant for AMP = 11585.
  int          inc_tab [4] = '{0, 1, 3, 2};
  logic [15:0] i_tab   [4] = '{16'h2D41, 16'hD2BF, 16'hD2BF, 16'h2D41};
  logic [15:0] q_tab   [4] = '{16'h2D41, 16'h2D41, 16'hD2BF, 16'hD2BF};

  dqpsk_symbol_mapper #(.SPS(SPS_A), .REF_EN(1'b1)) u_a (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n[0]),
    .s00_axis_tvalid(s_vld[0]), .s00_axis_tready(s_rdy[0]), .s00_axis_tdata(s_dat[0]),
    .s00_axis_tstrb(s_strb[0]), .s00_axis_tlast(s_lst[0]),
    .m00_axis_tvalid(m_vld[0]), .m00_axis_tready(m_rdy[0]), .m00_axis_tdata(m_dat[0]),
    .m00_axis_tstrb(m_strb[0]), .m00_axis_tlast(m_lst[0])
  );

  dqpsk_symbol_mapper #(.SPS(SPS_B), .REF_EN(1'b0)) u_b (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n[1]),
    .s00_axis_tvalid(s_vld[1]), .s00_axis_tready(s_rdy[1]), .s00_axis_tdata(s_dat[1]),
    .s00_axis_tstrb(s_strb[1]), .s00_axis_tlast(s_lst[1]),
    .m00_axis_tvalid(m_vld[1]), .m00_axis_tready(m_rdy[1]), .m00_axis_tdata(m_dat[1]),
    .m00_axis_tstrb(m_strb[1]), .m00_axis_tlast(m_lst[1])
  );

  task automatic check(input string nm, input int u, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s (unit %0d) at %0t: got %h, expected %h", nm, u, $time, act, req);
    end
  endtask

  function automatic exp_t mk(input int k, input bit l);
    return {i_tab[k], q_tab[k], l};
  endfunction

  function automatic int qsize(input int u);
    return (u == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic push(input int u, input exp_t e);
    if (u == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Model a whole frame from dbuf, queue its expected samples, then drive its dibits.
  task automatic send_frame(input int u, input int n);
    int  k    = 0;
    int  sps  = (u == 0) ? SPS_A : SPS_B;
    bit  refe = (u == 0);
    int  t;
    bit  ok;
    if (refe)
      for (int s = 0; s < sps; s++) push(u, mk(0, 1'b0));
    for (int i = 0; i < n; i++) begin
      k = (k + inc_tab[dbuf[u][i]]) % 4;
      for (int s = 0; s < sps; s++) push(u, mk(k, (i == n - 1) && (s == sps - 1)));
    end
    for (int i = 0; i < n; i++) begin
      if (gap_en[u]) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      s_vld[u]  = 1'b1;
      s_dat[u]  = {6'($urandom), dbuf[u][i]};
      s_strb[u] = 1'($urandom);
      s_lst[u]  = (i == n - 1);
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 400) begin
        @(negedge clk);
        if (s_rdy[u]) ok = 1'b1;
        t++;
      end
      if (!ok) begin
        n_chk++;
        n_err++;
        $display("FAIL input_handshake_timeout (unit %0d): tready stayed 0, expected 1 within 400 cycles", u);
      end
      @(posedge clk);
      #1;
      s_vld[u] = 1'b0;
      s_lst[u] = 1'b0;
    end
  endtask

  task automatic rdy_drv(input int u);
    forever begin
      @(posedge clk);
      #1;
      case (rmode[u])
        0:       m_rdy[u] = 1'b1;
        1:       m_rdy[u] = 1'($urandom_range(0, 1));
        default: m_rdy[u] = ~m_rdy[u];
      endcase
    end
  endtask

  // Scoreboard monitor: pops on every output beat, checks stall stability, strobes and one-cycle latency.
  task automatic monitor(input int u);
    bit   held = 1'b0;
    bit   pend = 1'b0;
    exp_t hv;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!sb_en[u]) begin
        held = 1'b0;
        pend = 1'b0;
      end else begin
        if (pend) check("first_sample_latency", u, 64'(m_vld[u]), 64'd1);
        if (held) begin
          check("stall_tvalid_held", u, 64'(m_vld[u]), 64'd1);
          check("stall_data_held", u, 64'({m_dat[u], m_lst[u]}), 64'(hv));
        end
        check("tstrb", u, 64'(m_strb[u]), m_vld[u] ? 64'hF : 64'h0);
        if (m_vld[u] && m_rdy[u]) begin
          if (qsize(u) == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_beat (unit %0d): got %h/%b, expected no beat", u, m_dat[u], m_lst[u]);
          end else begin
            e = (u == 0) ? q_a.pop_front() : q_b.pop_front();
            check("beat_data_last", u, 64'({m_dat[u], m_lst[u]}), 64'(e));
          end
        end
        held = m_vld[u] && !m_rdy[u];
        hv   = {m_dat[u], m_lst[u]};
        pend = s_vld[u] && s_rdy[u];
      end
    end
  endtask

  task automatic drain(input int u);
    int t = 0;
    while (qsize(u) != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("drain_queue_empty", u, 64'(qsize(u)), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string nm, input int u);
    check({nm, "_tvalid"}, u, 64'(m_vld[u]), 64'd0);
    check({nm, "_tdata"}, u, 64'(m_dat[u]), 64'd0);
    check({nm, "_tstrb"}, u, 64'(m_strb[u]), 64'd0);
    check({nm, "_tlast"}, u, 64'(m_lst[u]), 64'd0);
    check({nm, "_s_tready"}, u, 64'(s_rdy[u]), 64'd0);
  endtask

  task automatic rand_run(input int u);
    int n;
    repeat (20) begin
      rmode[u]  = $urandom_range(0, 2);
      gap_en[u] = 1'($urandom);
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) dbuf[u][i] = 2'($urandom);
      send_frame(u, n);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u]  = 1'b0;
      s_vld[u]  = 1'b0;
      s_dat[u]  = '0;
      s_strb[u] = '0;
      s_lst[u]  = 1'b0;
      m_rdy[u]  = 1'b1;
      sb_en[u]  = 1'b0;
      rmode[u]  = 0;
      gap_en[u] = 1'b0;
    end
    fork
      rdy_drv(0);
      rdy_drv(1);
      monitor(0);
      monitor(1);
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset", 0);
    check_outputs_zero("reset", 1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;
    sb_en[0] = 1'b1;
    sb_en[1] = 1'b1;

    // Single dibit 00 with tlast: reference plus one data symbol, both at phase 0.
    dbuf[0][0] = 2'b00;
    send_frame(0, 1);
    drain(0);

    // Frame 01, 11, 10 with steady ready, then with ready toggling every cycle.
    dbuf[0][0] = 2'b01; dbuf[0][1] = 2'b11; dbuf[0][2] = 2'b10;
    send_frame(0, 3);
    drain(0);
    rmode[0] = 2;
    send_frame(0, 3);
    drain(0);
    rmode[0] = 0;

    // Back-to-back frames: first ends at k=2, second must restart with a reference.
    send_frame(0, 3);
    dbuf[0][0] = 2'b01;
    send_frame(0, 1);
    drain(0);

    // One sample per symbol, no reference: dibit 01 with random upper bits.
    dbuf[1][0] = 2'b01;
    send_frame(1, 1);
    drain(1);

    // Asynchronous reset mid-reference at cnt=2, then a fresh frame of dibit 11.
    sb_en[0]   = 1'b0;
    dbuf[0][0] = 2'b11;
    send_frame(0, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst_n[0] = 1'b0;
    #1;
    check_outputs_zero("async_reset", 0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    q_a.delete();
    @(posedge clk);
    #1;
    sb_en[0] = 1'b1;
    send_frame(0, 1);
    drain(0);

    // Randomized frames, ready patterns and input gaps on both units concurrently.
    fork
      rand_run(0);
      rand_run(1);
    join
    for (int u = 0; u < 2; u++) rmode[u] = 0;
    drain(0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dqpsk_symbol_mapper.md
Name: dqpsk_symbol_mapper

Overview:
- Transmit-side counterpart of the receive phase-recovery path. It maps 2-bit Gray-coded dibits onto differentially encoded QPSK IQ samples.
- Accepts dibits on an AXI-Stream slave and emits 32-bit {I,Q} samples on an AXI-Stream master, each symbol held for SPS samples.
- Inserts one phase-0 reference symbol at the start of every frame, so the receiver always has a prior sample to measure phase difference against.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 8: input stream width; only bits [1:0] are used.
- C_M00_AXIS_TDATA_WIDTH, 32: output stream width; {I[31:16], Q[15:0]}, both signed.
- SPS, 4: samples per symbol, at least 1; rectangular pulse.
- AMP, 11585: signed 16-bit per-axis magnitude, approximately 16384/sqrt(2).
- REF_EN, 1: 1 inserts a reference symbol at frame start; 0 disables insertion.

Ports:
- s00_axis_aclk  in  1  the single clock; the master side also runs on it.
- s00_axis_aresetn  in  1  asynchronous, active-low reset.
- s00_axis_tvalid  in  1  input dibit valid.
- s00_axis_tready  out  1  block can accept a dibit.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  [1:0] = dibit; upper bits ignored.
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored.
- s00_axis_tlast  in  1  dibit is the last in its frame.
- m00_axis_tvalid  out  1  output sample valid.
- m00_axis_tready  in  1  downstream accepts the sample.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  {I,Q} sample.
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  all ones when valid, else 0.
- m00_axis_tlast  out  1  final sample of the frame's last data symbol.

Behaviour:
- Reset: asynchronous on falling s00_axis_aresetn.
  - m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb and m00_axis_tlast all go to 0.
  - Phase index, sample counter and pending dibit/tlast registers clear; state goes to IDLE; frame_start = 1.
  - s00_axis_tready is forced to 0 while reset is low.
- Gray increment: 00→0, 01→1, 11→2, 10→3. Phase index k (2 bits) updates as k_new = (k + inc) mod 4.
- Constellation: k=0 → (+AMP,+AMP); k=1 → (−AMP,+AMP); k=2 → (−AMP,−AMP); k=3 → (+AMP,−AMP).
- Sample counter cnt (0..SPS−1) advances only on an output beat (m00_axis_tvalid & m00_axis_tready).
- State machine:
  - IDLE: s00_axis_tready = 1. On input handshake, latch the dibit and tlast.
    - If REF_EN and frame_start: go to REF. Next cycle present k=0 with tvalid = 1.
    - Otherwise: compute k_new, go to DATA, present the k_new sample next cycle.
    - In both cases clear frame_start.
  - REF: s00_axis_tready = 0. Emit SPS beats of k=0 with tlast = 0. On the beat where cnt = SPS−1, load k = 0 + inc and go to DATA.
  - DATA: emit SPS beats of k. m00_axis_tlast = latched tlast AND cnt = SPS−1.
    - s00_axis_tready = (cnt = SPS−1) & m00_axis_tready. This is combinational from m00_axis_tready and permits back-to-back symbols.
    - On the final beat with a new input handshake: latch the new dibit, update k, reset cnt; the next cycle shows the new symbol with no bubble.
    - On the final beat without an input handshake: go to IDLE, tvalid = 0 next cycle.
    - If the final beat carries tlast: reset k to 0 and set frame_start. A same-cycle new input is treated as a frame start, so with REF_EN it goes to REF.
- Latency: first output sample is valid the cycle after the input handshake.
- Stalls: while m00_axis_tvalid & !m00_axis_tready, m00_axis_tdata and m00_axis_tlast are held stable, and tvalid never drops before the beat completes.
- Output is registered; no combinational path from any s00 input to any m00 output.
- SPS = 1: every beat is a final beat; the same rules apply.

Test Plan:
- Scenario 1: SPS=4, REF_EN=1, m00_axis_tready=1; send dibit 00 with tlast → 8 beats of 0x2D412D41, tlast only on beat 8, s00_axis_tready low from acceptance until beat 8.
- Scenario 2: frame 01, 11, 10 (tlast on last), tready=1 → 4×0x2D412D41 (ref), 4×0xD2BF2D41 (k=1), 4×0x2D41D2BF (k=3), 4×0xD2BFD2BF (k=2). tlast on beat 16; no idle cycle between symbols.
- Scenario 3: repeat Scenario 2 with m00_axis_tready toggling 1,0,1,0 → same 16-beat sequence; tdata and tlast stable through every stall; no lost or duplicated beats.
- Scenario 4: two frames back-to-back, first ending at k=2, second = dibit 01 → second frame begins with 4×0x2D412D41 reference, then 4×0xD2BF2D41.
- Scenario 5: pull aresetn low asynchronously mid-symbol at cnt=2 → all m00 outputs are 0 before the next clock edge; after release, dibit 11 yields reference 0x2D412D41 followed by 0xD2BFD2BF.
- Scenario 6: REF_EN=0, SPS=1, input tdata 0xFD (dibit 01) → single beat 0xD2BF2D41 one cycle after acceptance, identical to input 0x01.
